// File: rtl/bf16_pkg.sv
// Shared bfloat16 format constants and divider state encoding.
package bf16_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int MANT_W = FRAC_W + 1;
  localparam int Q_W    = 10;
  localparam int E_W    = 10;
  localparam int BIAS   = 127;

  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [15:0] BF16_POS_INF = 16'h7F80;

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
endpackage

// File: rtl/bf16_round_pack.sv
// Normalise the 10-bit quotient, round to nearest even, range-check the
// exponent and pack a bf16 result.
module bf16_round_pack
  import bf16_pkg::*;
(
  input  logic                  s,
  input  logic [Q_W-1:0]        q,
  input  logic                  rem_nz,
  input  logic signed [E_W-1:0] e_in,    // Ea - Eb + BIAS, before normalisation
  output logic [15:0]           result,
  output logic                  ov,
  output logic                  uf
);
  logic [FRAC_W-1:0]   frac;
  logic [FRAC_W-1:0]   frac_r;
  logic                rnd, stk, inc, cy;
  logic signed [E_W-1:0] e_n, e_r;

  // Quotient lies in [0.5, 2): a clear integer bit costs one exponent step.
  always_comb begin
    frac   = q[8:2];
    rnd    = q[1];
    stk    = q[0] | rem_nz;
    e_n    = e_in;
    if (!q[9]) begin
      frac = q[7:1];
      rnd  = q[0];
      stk  = rem_nz;
      e_n  = e_in - 10'sd1;
    end
    inc          = rnd & (stk | frac[0]);
    {cy, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
    e_r          = e_n + $signed({{(E_W-1){1'b0}}, cy});
    ov           = (e_r >= 10'sd255);
    uf           = (e_r <= 10'sd0);
    if (ov)      result = {s, BF16_POS_INF[14:0]};
    else if (uf) result = {s, 15'h0};
    else         result = {s, e_r[EXP_W-1:0], frac_r};
  end
endmodule

// File: rtl/bf16_divider.sv
// Iterative bf16 divider: latch, 10 restoring-division steps, round/pack.
// Fixed 11-cycle latency for every operand class.
module bf16_divider
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] result,
  output logic        ov,
  output logic        uf,
  output logic        dz,
  output logic        nv,
  output logic        busy,
  output logic        done
);
  state_t                state;
  logic [3:0]            cnt;
  logic                  s;
  logic signed [E_W-1:0] e;
  logic [MANT_W:0]       r;
  logic [MANT_W-1:0]     mb;
  logic [Q_W-1:0]        q;
  logic                  spec, spec_dz, spec_nv;
  logic [15:0]           spec_res;

  logic                  s_n;
  logic                  a_zero, b_zero, a_max, b_max;
  logic                  spec_n, spec_dz_n, spec_nv_n;
  logic [15:0]           spec_res_n;
  logic signed [E_W-1:0] e_n;
  logic [MANT_W:0]       r_sub;
  logic [15:0]           rp_result;
  logic                  rp_ov, rp_uf;

  // Classify incoming operands so special results are fixed at latch time.
  always_comb begin
    s_n        = A[15] ^ B[15];
    a_zero     = (A[14:7] == 8'h00);
    b_zero     = (B[14:7] == 8'h00);
    a_max      = (A[14:7] == 8'hFF);
    b_max      = (B[14:7] == 8'hFF);
    spec_n     = 1'b1;
    spec_dz_n  = 1'b0;
    spec_nv_n  = 1'b0;
    spec_res_n = 16'h0;
    if (a_max || b_max || (a_zero && b_zero)) begin
      spec_nv_n  = 1'b1;
      spec_res_n = BF16_QNAN;
    end else if (a_zero) begin
      spec_res_n = {s_n, 15'h0};
    end else if (b_zero) begin
      spec_dz_n  = 1'b1;
      spec_res_n = {s_n, BF16_POS_INF[14:0]};
    end else begin
      spec_n     = 1'b0;
    end
    e_n   = $signed({2'b00, A[14:7]}) - $signed({2'b00, B[14:7]}) + 10'sd127;
    r_sub = r - {1'b0, mb};
  end

  bf16_round_pack u_rp (
    .s      (s),
    .q      (q),
    .rem_nz (r != '0),
    .e_in   (e),
    .result (rp_result),
    .ov     (rp_ov),
    .uf     (rp_uf)
  );

  // Control FSM plus datapath registers; outputs registered in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      s        <= 1'b0;
      e        <= '0;
      r        <= '0;
      mb       <= '0;
      q        <= '0;
      spec     <= 1'b0;
      spec_dz  <= 1'b0;
      spec_nv  <= 1'b0;
      spec_res <= '0;
      result   <= '0;
      ov       <= 1'b0;
      uf       <= 1'b0;
      dz       <= 1'b0;
      nv       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= DIV;
          busy     <= 1'b1;
          cnt      <= '0;
          s        <= s_n;
          e        <= e_n;
          r        <= {2'b01, A[6:0]};
          mb       <= {1'b1, B[6:0]};
          q        <= '0;
          spec     <= spec_n;
          spec_dz  <= spec_dz_n;
          spec_nv  <= spec_nv_n;
          spec_res <= spec_res_n;
          ov       <= 1'b0;
          uf       <= 1'b0;
          dz       <= 1'b0;
          nv       <= 1'b0;
        end
        DIV: begin
          if (r >= {1'b0, mb}) begin
            r <= {r_sub[MANT_W-1:0], 1'b0};
            q <= {q[Q_W-2:0], 1'b1};
          end else begin
            r <= {r[MANT_W-1:0], 1'b0};
            q <= {q[Q_W-2:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= ROUND;
        end
        ROUND: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (spec) begin
            result <= spec_res;
            dz     <= spec_dz;
            nv     <= spec_nv;
          end else begin
            result <= rp_result;
            ov     <= rp_ov;
            uf     <= rp_uf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
